// File: rtl/tt_um_multi_pattern_led_sequencer_rsyo3000.sv
// Multi-pattern LED sequencer: a selectable-rate step tick drives a step counter
// and an 8-bit LFSR, from which one of 32 LED patterns is picked and registered.
module tt_um_multi_pattern_led_sequencer_rsyo3000 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned DIV_W = 22;
  localparam int unsigned LED_W = 8;
  localparam int unsigned PWM_W = 3;

  logic [1:0] clk_sel;
  logic [4:0] pat_sel;
  logic       unused_ok;

  assign clk_sel   = ui_in[1:0];
  assign pat_sel   = ui_in[6:2];
  assign unused_ok = &{1'b0, ena, ui_in[7], uio_in};

  logic [DIV_W-1:0] div_q, div_d;
  logic [LED_W-1:0] s_q, s_d;
  logic [LED_W-1:0] lfsr_q, lfsr_d;
  logic [PWM_W-1:0] w_q, w_d;
  logic [LED_W-1:0] uo_q, uo_d;

  logic [DIV_W-1:0] div_last_c;
  logic             tick_c;
  logic             lfsr_fb_c;

  // Terminal count for the selected rate; >= keeps a rate switch from skipping a tick.
  always_comb begin
    div_last_c = DIV_W'(22'h00FFFF);
    case (clk_sel)
      2'd0:    div_last_c = DIV_W'(22'h3FFFFF);
      2'd1:    div_last_c = DIV_W'(22'h0FFFFF);
      2'd2:    div_last_c = DIV_W'(22'h03FFFF);
      default: div_last_c = DIV_W'(22'h00FFFF);
    endcase
  end

  assign tick_c    = (div_q >= div_last_c);
  assign lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Derived sweep indices
  logic [2:0] b_c;
  logic [1:0] q_c;
  logic [2:0] r_c;
  logic [2:0] g_c;
  logic [2:0] pp_c;

  assign b_c  = s_q[3] ? ~s_q[2:0] : s_q[2:0];
  assign q_c  = s_q[2] ? ~s_q[1:0] : s_q[1:0];
  assign pp_c = s_q[4] ? ~s_q[3:1] : s_q[3:1];
  assign r_c  = s_q[5] ? b_c : pp_c;

  // Fibonacci-like spacing for the comet pattern
  always_comb begin
    g_c = 3'd0;
    case (s_q[2:0])
      3'd0:    g_c = 3'd0;
      3'd1:    g_c = 3'd0;
      3'd2:    g_c = 3'd1;
      3'd3:    g_c = 3'd1;
      3'd4:    g_c = 3'd2;
      3'd5:    g_c = 3'd3;
      3'd6:    g_c = 3'd5;
      default: g_c = 3'd7;
    endcase
  end

  logic [LED_W-1:0] one_s_c;
  logic [LED_W-1:0] one_b_c;
  logic [LED_W-1:0] kr_c;
  logic [LED_W-1:0] mirror_c;
  logic [3:0]       fill_sh_c;
  logic [LED_W-1:0] fill_c;
  logic [LED_W-1:0] rot11_c;
  logic [3:0]       nib_c;
  logic [LED_W-1:0] bar_c;

  assign one_s_c   = LED_W'(8'd1) << s_q[2:0];
  assign one_b_c   = LED_W'(8'd1) << b_c;
  assign kr_c      = one_b_c | (one_b_c << 1) | (one_b_c >> 1);
  assign mirror_c  = one_b_c | (LED_W'(8'h80) >> b_c);
  assign fill_sh_c = {1'b0, s_q[2:0]} + 4'd1;
  assign fill_c    = s_q[3] ? (LED_W'(8'hFF) << fill_sh_c)
                            : (LED_W'(8'hFF) >> (3'd7 - s_q[2:0]));
  // 8'h11 has period 4, so a plain shift by 0..3 is the same as a rotate.
  assign rot11_c   = LED_W'(8'h11) << s_q[1:0];
  assign nib_c     = 4'd1 << q_c;

  always_comb begin
    bar_c = 8'h18;
    case (q_c)
      2'd0:    bar_c = 8'h18;
      2'd1:    bar_c = 8'h3C;
      2'd2:    bar_c = 8'h7E;
      default: bar_c = 8'hFF;
    endcase
  end

  // Pattern select
  logic [LED_W-1:0] led_c;

  always_comb begin
    led_c = '0;
    case (pat_sel)
      5'd0:    led_c = 8'h00;
      5'd1:    led_c = 8'hFF;
      5'd2:    led_c = s_q[0] ? 8'hFF : 8'h00;
      5'd3:    led_c = one_s_c;
      5'd4:    led_c = s_q[0] ? 8'hAA : 8'h55;
      5'd5:    led_c = ~one_s_c;
      5'd6:    led_c = kr_c;
      5'd7:    led_c = one_b_c;
      5'd8:    led_c = fill_c;
      5'd9:    led_c = s_q[0] ? 8'hF0 : 8'h0F;
      5'd10:   led_c = ((s_q[2:0] == 3'd0) || (s_q[2:0] == 3'd2)) ? 8'hFF : 8'h00;
      5'd11:   led_c = lfsr_q;
      5'd12:   led_c = s_q ^ lfsr_q;
      5'd13:   led_c = s_q;
      5'd14:   led_c = LED_W'(8'h80) >> s_q[2:0];
      5'd15:   led_c = s_q ^ {s_q[3:0], s_q[7:4]};
      5'd16:   led_c = one_b_c;
      5'd17:   led_c = mirror_c;
      5'd18:   led_c = rot11_c;
      5'd19:   led_c = LED_W'(8'd1) << lfsr_q[2:0];
      5'd20:   led_c = ~mirror_c;
      5'd21:   led_c = LED_W'(8'd1) << r_c;
      5'd22:   led_c = LED_W'(8'h80) >> g_c;
      5'd23:   led_c = bar_c;
      5'd24:   led_c = s_q[4] ? (LED_W'(8'h80) >> b_c) : one_b_c;
      5'd25:   led_c = {nib_c, nib_c};
      5'd26:   led_c = LED_W'(8'h0F) << q_c;
      5'd27:   led_c = (w_q < b_c) ? 8'hFF : 8'h00;
      5'd28:   led_c = s_q[4] ? s_q : one_s_c;
      5'd29:   led_c = s_q[4] ? lfsr_q : one_s_c;
      5'd30:   led_c = s_q[4] ? lfsr_q : s_q;
      default: led_c = 8'h00;
    endcase
  end

  // Next-state: divider, step counter, LFSR, PWM phase, LED register
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    s_d    = s_q;
    lfsr_d = lfsr_q;
    w_d    = w_q + PWM_W'(1);
    uo_d   = led_c;
    if (tick_c) begin
      div_d  = '0;
      s_d    = s_q + LED_W'(1);
      lfsr_d = {lfsr_q[6:0], lfsr_fb_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      s_q    <= '0;
      lfsr_q <= LED_W'(8'h01);
      w_q    <= '0;
      uo_q   <= '0;
    end else begin
      div_q  <= div_d;
      s_q    <= s_d;
      lfsr_q <= lfsr_d;
      w_q    <= w_d;
      uo_q   <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_multi_pattern_led_sequencer_rsyo3000.sv
// Directed bench for the LED sequencer; the divider and step counter are preloaded
// with force/release so that multi-tick sequences fit in a short run.
module tb_tt_um_multi_pattern_led_sequencer_rsyo3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  tt_um_multi_pattern_led_sequencer_rsyo3000 dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; the PWM phase is (cyc-1) mod 8 when an output is formed.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [4:0] pat;
    logic [7:0] s;
    logic [7:0] exp;
  } vec_t;

  localparam int unsigned NV = 49;
  localparam vec_t VECS [NV] = '{
    '{5'd0,  8'h5A, 8'h00}, '{5'd1,  8'h5A, 8'hFF}, '{5'd2,  8'h01, 8'hFF},
    '{5'd2,  8'h02, 8'h00}, '{5'd4,  8'h01, 8'hAA}, '{5'd4,  8'h02, 8'h55},
    '{5'd5,  8'h03, 8'hF7}, '{5'd6,  8'h03, 8'h1C}, '{5'd6,  8'h00, 8'h03},
    '{5'd6,  8'h07, 8'hC0}, '{5'd6,  8'h0F, 8'h03}, '{5'd8,  8'h02, 8'h07},
    '{5'd8,  8'h0A, 8'hF8}, '{5'd8,  8'h0F, 8'h00}, '{5'd8,  8'h07, 8'hFF},
    '{5'd9,  8'h01, 8'hF0}, '{5'd10, 8'h02, 8'hFF}, '{5'd10, 8'h03, 8'h00},
    '{5'd11, 8'h77, 8'h01}, '{5'd12, 8'hF0, 8'hF1}, '{5'd14, 8'h03, 8'h10},
    '{5'd15, 8'h12, 8'h33}, '{5'd16, 8'h0B, 8'h10}, '{5'd17, 8'h02, 8'h24},
    '{5'd18, 8'h03, 8'h88}, '{5'd18, 8'h01, 8'h22}, '{5'd19, 8'h55, 8'h02},
    '{5'd20, 8'h02, 8'hDB}, '{5'd21, 8'h2A, 8'h20}, '{5'd21, 8'h12, 8'h40},
    '{5'd21, 8'h06, 8'h08}, '{5'd22, 8'h06, 8'h04}, '{5'd22, 8'h07, 8'h01},
    '{5'd22, 8'h00, 8'h80}, '{5'd23, 8'h05, 8'h7E}, '{5'd23, 8'h00, 8'h18},
    '{5'd24, 8'h12, 8'h20}, '{5'd24, 8'h02, 8'h04}, '{5'd25, 8'h07, 8'h11},
    '{5'd25, 8'h01, 8'h22}, '{5'd26, 8'h02, 8'h3C}, '{5'd28, 8'h13, 8'h13},
    '{5'd28, 8'h03, 8'h08}, '{5'd29, 8'h13, 8'h01}, '{5'd29, 8'h05, 8'h20},
    '{5'd30, 8'h10, 8'h01}, '{5'd30, 8'h0C, 8'h0C}, '{5'd31, 8'hFF, 8'h00},
    '{5'd13, 8'hA5, 8'hA5}
  };

  localparam logic [7:0] BOUNCE_EXP [9] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04,
                                            8'h02, 8'h01, 8'h01, 8'h02};
  localparam logic [7:0] LFSR_EXP [4]   = '{8'h02, 8'h04, 8'h08, 8'h11};
  localparam logic [21:0] LAST [4]      = '{22'h3FFFFF, 22'h0FFFFF, 22'h03FFFF, 22'h00FFFF};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [4:0] pat, input logic [1:0] cs);
    ui_in = {1'b0, pat, cs};
  endtask

  task set_div(input logic [21:0] v);
    force dut.div_q = v;
    #1;
    release dut.div_q;
  endtask

  task set_s(input logic [7:0] v);
    force dut.s_q = v;
    #1;
    release dut.s_q;
  endtask

  // Force an immediate tick, then let the LED register catch up
  task do_tick();
    set_div(22'h3FFFFF);
    step(2);
  endtask

  initial begin
    logic [7:0] s_exp;
    logic [7:0] pwm_exp;

    // Reset behaviour with pattern 1
    sel(5'd1, 2'd3);
    step(2);
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h00);
    rst = 1'b0;
    step(1);
    chk("rel_pat1", uo_out, 8'hFF);

    // Honest first interval at clk_sel=3: tick on the 65536th clock after release
    sel(5'd13, 2'd3);
    step(65534);
    chk("first_tick_pre", uo_out, 8'h00);
    step(1);
    chk("first_tick_edge", uo_out, 8'h00);
    step(1);
    chk("first_tick_post", uo_out, 8'h01);
    do_tick();
    chk("count_02", uo_out, 8'h02);
    set_s(8'hFE);
    step(1);
    chk("count_FE", uo_out, 8'hFE);
    do_tick();
    chk("count_FF", uo_out, 8'hFF);
    do_tick();
    chk("count_wrap", uo_out, 8'h00);

    // Walking one, then bouncing dot
    sel(5'd3, 2'd3);
    step(1);
    chk("walk_0", uo_out, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      chk($sformatf("walk_%0d", i), uo_out, 8'h01 << (i % 8));
    end
    sel(5'd7, 2'd3);
    step(1);
    chk("bounce_s8", uo_out, 8'h80);
    for (int i = 0; i < 9; i++) begin
      do_tick();
      chk($sformatf("bounce_s%0d", 9 + i), uo_out, BOUNCE_EXP[i]);
    end

    // Fresh reset so lfsr=01, then pattern table with preloaded s
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < int'(NV); i++) begin
      set_s(VECS[i].s);
      sel(VECS[i].pat, 2'd3);
      step(1);
      chk($sformatf("pat%0d_s%02h", VECS[i].pat, VECS[i].s), uo_out, VECS[i].exp);
    end
    chk("tbl_uio_oe", uio_oe, 8'h00);

    // PWM pattern with b=3
    set_s(8'h03);
    sel(5'd27, 2'd3);
    for (int i = 0; i < 8; i++) begin
      step(1);
      pwm_exp = (((cyc - 1) % 8) < 3) ? 8'hFF : 8'h00;
      chk($sformatf("pwm_%0d", i), uo_out, pwm_exp);
    end

    // Mid-sequence reset is asynchronous and restarts s and lfsr
    sel(5'd1, 2'd3);
    step(1);
    chk("pre_rst_ff", uo_out, 8'hFF);
    rst = 1'b1;
    #1;
    chk("async_rst", uo_out, 8'h00);
    step(1);
    chk("held_rst", uo_out, 8'h00);
    rst = 1'b0;
    sel(5'd11, 2'd3);
    step(1);
    chk("lfsr_init", uo_out, 8'h01);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk($sformatf("lfsr_%0d", i + 1), uo_out, LFSR_EXP[i]);
    end
    sel(5'd12, 2'd3);
    step(1);
    chk("s_xor_lfsr", uo_out, 8'h15);
    sel(5'd13, 2'd3);
    step(1);
    chk("s_restart", uo_out, 8'h04);

    // Terminal count per rate: no tick at N-2, tick at N-1
    s_exp = 8'h04;
    for (int cs = 0; cs < 4; cs++) begin
      sel(5'd13, 2'(cs));
      set_div(LAST[cs] - 22'd1);
      step(1);
      chk($sformatf("tc%0d_nm2", cs), uo_out, s_exp);
      step(1);
      chk($sformatf("tc%0d_nm1", cs), uo_out, s_exp);
      step(1);
      s_exp = s_exp + 8'd1;
      chk($sformatf("tc%0d_post", cs), uo_out, s_exp);
    end

    // Rate switch 0->3 with divider at 2^18 ticks on the next clock
    sel(5'd13, 2'd0);
    set_div(22'h040000);
    step(1);
    chk("sw_no_tick", uo_out, s_exp);
    sel(5'd13, 2'd3);
    step(1);
    chk("sw_edge", uo_out, s_exp);
    step(1);
    s_exp = s_exp + 8'd1;
    chk("sw_tick", uo_out, s_exp);

    // Blank patterns stay dark across ticks
    sel(5'd0, 2'd3);
    step(1);
    chk("pat0_a", uo_out, 8'h00);
    do_tick();
    chk("pat0_b", uo_out, 8'h00);
    sel(5'd31, 2'd3);
    set_s(8'hFF);
    step(1);
    chk("pat31_a", uo_out, 8'h00);
    do_tick();
    chk("pat31_b", uo_out, 8'h00);
    ui_in = 8'hFF;
    uio_in = 8'hFF;
    step(1);
    chk("bit7_pat31", uo_out, 8'h00);
    chk("end_uio_out", uio_out, 8'h00);
    chk("end_uio_oe", uio_oe, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_multi_pattern_led_sequencer_rsyo3000.md
TT_UM_MULTI_PATTERN_LED_SEQUENCER_RSYO3000 -- requirements
Module: tt_um_multi_pattern_led_sequencer_rsyo3000

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ena, input, 1 bit: design-enabled flag; ignored.
REQ-004 SHALL have port ui_in, input, 8 bits: [1:0] clk_sel step-rate select; [6:2] pat_sel pattern select; [7] unused.
REQ-005 SHALL have port uio_in, input, 8 bits: unused.
REQ-006 SHALL have port uo_out, output, 8 bits: LED drive, bit 0 = LED0.
REQ-007 SHALL have ports uio_out and uio_oe, output, 8 bits each: tied to 8'h00.

Function
REQ-008 SHALL contain a 22-bit divider that counts clocks; tick asserts for one clock when divider >= N-1, and divider then returns to 0; otherwise divider increments.
REQ-009 N SHALL be 2^22, 2^20, 2^18 or 2^16 for clk_sel 0, 1, 2 or 3; changing clk_sel mid-count takes effect immediately, and the >= compare guarantees a tick.
REQ-010 On each tick: step counter s[7:0] SHALL increment, wrapping FF->00; lfsr[7:0] SHALL shift left, inserting lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] at bit 0.
REQ-011 A free-running 3-bit PWM counter w SHALL increment every clock.
REQ-012 Derived values: b = s[3] ? ~s[2:0] : s[2:0] (0..7..0); q = s[2] ? ~s[1:0] : s[1:0] (0..3..0); r = s[5] ? b : ping-pong of s[4:1].
REQ-013 uo_out SHALL be registered, updating one clock after any change of pat_sel, s, lfsr or w; pat_sel changes do not reset s or lfsr.
REQ-014 Patterns 0-15: 0 00; 1 FF; 2 s[0]?FF:00; 3 1<<s[2:0]; 4 s[0]?AA:55; 5 ~(1<<s[2:0]); 6 KR, (1<<b)|((1<<b)<<1)|((1<<b)>>1); 7 1<<b; 8 s[3] ? FF<<(s[2:0]+1) : FF>>(7-s[2:0]); 9 s[0]?F0:0F; 10 FF when s[2:0] is 0 or 2, else 00; 11 lfsr; 12 s^lfsr; 13 s; 14 80>>s[2:0]; 15 s^{s[3:0],s[7:4]}.
REQ-015 Patterns 16-23: 16 same as 7; 17 (1<<b)|(80>>b); 18 8'h11 rotated left by s[1:0]; 19 1<<lfsr[2:0]; 20 ~pattern17; 21 1<<r; 22 80>>g, g={0,0,1,1,2,3,5,7}[s[2:0]]; 23 {18,3C,7E,FF}[q].
REQ-016 Patterns 24-31: 24 s[4] ? 80>>b : 1<<b; 25 {1<<q, 1<<q} as two nibbles; 26 0F<<q; 27 (w < b) ? FF : 00; 28 s[4] ? s : 1<<s[2:0]; 29 s[4] ? lfsr : 1<<s[2:0]; 30 s[4] ? lfsr : s; 31 00.
REQ-017 All shifts SHALL be 8-bit logical shifts; bits shifted beyond bit 7 are discarded.

Reset
REQ-018 While rst=1: divider=0, s=00, lfsr=01, w=0, uo_out=00, asynchronously.
REQ-019 Reset asserted mid-sequence SHALL restart from the REQ-018 values; first tick comes N clocks after rst deasserts.

Verification
REQ-020 rst pulse with pat_sel=1 -> uo_out=00 during reset, FF one clock after release.
REQ-021 clk_sel=3, pat_sel=13 -> uo_out 00,01,02,... changing every 65536 clocks; wraps FF->00.
REQ-022 clk_sel=3, pat_sel=3 -> uo_out 01,02,04,...,80,01 per tick; pat_sel=7 -> 01..80,80..01.
REQ-023 pat_sel=11 from reset -> successive ticks give lfsr 02,04,08,11.
REQ-024 Change clk_sel 0->3 with divider at 2^18 -> tick on the next clock (>= rule).
REQ-025 pat_sel=31 and pat_sel=0 -> uo_out=00 always; uio_out=uio_oe=00 in every mode.
